// File: rtl/llc_input_buffers_pkg.sv
// rtl/llc_input_buffers_pkg.sv - payload types and FIFO depth for the LLC input buffers
package llc_input_buffers_pkg;

  localparam int LLC_IN_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  coh_msg;
    logic [27:0] line;
    logic [1:0]  word_mask;
  } llc_rsp_in_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  coh_msg;
    logic        hprot;
    logic [41:0] line;
    logic [1:0]  word_mask;
  } llc_req_in_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  coh_msg;
    logic        hprot;
    logic [41:0] line;
    logic [1:0]  word_mask;
  } llc_dma_req_in_t;

  localparam int LLC_RSP_W = $bits(llc_rsp_in_t);
  localparam int LLC_REQ_W = $bits(llc_req_in_t);
  localparam int LLC_DMA_W = $bits(llc_dma_req_in_t);

endpackage

// File: rtl/llc_in_fifo.sv
// rtl/llc_in_fifo.sv - generic channel FIFO with combinational head read
// Optional same-cycle bypass of an empty FIFO under LLC_IN_BYPASS_EN.
module llc_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         pop_i,
  output logic         pop_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, byp, push, wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready is gated by reset so nothing is accepted while rst is held low.
  assign in_ready_o = rst & ~full;

`ifdef LLC_IN_BYPASS_EN
  assign byp = empty & in_valid_i & rst;
`else
  assign byp = 1'b0;
`endif

  assign out_valid_o = ~empty | byp;
  assign out_data_o  = byp ? in_data_i : mem_q[rd_ptr_q];

  assign push      = in_valid_i & in_ready_o;
  assign wr_en     = push & ~(byp & pop_i);
  assign rd_en     = pop_i & ~empty;
  assign pop_err_o = pop_i & ~out_valid_o;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/llc_input_buffers.sv
// rtl/llc_input_buffers.sv - per-channel input FIFOs, stalled-request register, pop-empty error
// Build option: LLC_IN_BYPASS_EN enables same-cycle bypass in each FIFO.
module llc_input_buffers
  import llc_input_buffers_pkg::*;
#(
  parameter int DEPTH = LLC_IN_FIFO_DEPTH,
  parameter int RSP_W = LLC_RSP_W,
  parameter int REQ_W = LLC_REQ_W,
  parameter int DMA_W = LLC_DMA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             llc_rst_tb_valid,
  output logic             llc_rst_tb_ready,
  input  logic             llc_rst_tb_data,
  input  logic             llc_rsp_in_valid,
  output logic             llc_rsp_in_ready,
  input  logic [RSP_W-1:0] llc_rsp_in_data,
  input  logic             llc_req_in_valid,
  output logic             llc_req_in_ready,
  input  logic [REQ_W-1:0] llc_req_in_data,
  input  logic             llc_dma_req_in_valid,
  output logic             llc_dma_req_in_ready,
  input  logic [DMA_W-1:0] llc_dma_req_in_data,
  output logic             llc_rst_tb_valid_int,
  output logic             llc_rst_tb_data_int,
  output logic             llc_rsp_in_valid_int,
  output logic [RSP_W-1:0] llc_rsp_in_data_int,
  output logic             llc_req_in_valid_int,
  output logic [REQ_W-1:0] llc_req_in_data_int,
  output logic             llc_dma_req_in_valid_int,
  output logic [DMA_W-1:0] llc_dma_req_in_data_int,
  input  logic             pop_rst_tb,
  input  logic             pop_rsp_in,
  input  logic             pop_req_in,
  input  logic             pop_dma_req_in,
  input  logic             set_req_in_stalled,
  input  logic [REQ_W-1:0] req_in_stalled_data_in,
  input  logic             clr_req_in_stalled_valid,
  output logic             req_in_stalled_valid,
  output logic [REQ_W-1:0] req_in_stalled_data,
  output logic             err_pop_empty
);

  logic [3:0]       pop_err;
  logic             stalled_valid_q;
  logic [REQ_W-1:0] stalled_data_q;
  logic             err_q;

  llc_in_fifo #(.W(1), .DEPTH(DEPTH)) u_rst_tb (
    .clk(clk), .rst(rst),
    .in_valid_i(llc_rst_tb_valid), .in_ready_o(llc_rst_tb_ready), .in_data_i(llc_rst_tb_data),
    .out_valid_o(llc_rst_tb_valid_int), .out_data_o(llc_rst_tb_data_int),
    .pop_i(pop_rst_tb), .pop_err_o(pop_err[0])
  );

  llc_in_fifo #(.W(RSP_W), .DEPTH(DEPTH)) u_rsp_in (
    .clk(clk), .rst(rst),
    .in_valid_i(llc_rsp_in_valid), .in_ready_o(llc_rsp_in_ready), .in_data_i(llc_rsp_in_data),
    .out_valid_o(llc_rsp_in_valid_int), .out_data_o(llc_rsp_in_data_int),
    .pop_i(pop_rsp_in), .pop_err_o(pop_err[1])
  );

  llc_in_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_req_in (
    .clk(clk), .rst(rst),
    .in_valid_i(llc_req_in_valid), .in_ready_o(llc_req_in_ready), .in_data_i(llc_req_in_data),
    .out_valid_o(llc_req_in_valid_int), .out_data_o(llc_req_in_data_int),
    .pop_i(pop_req_in), .pop_err_o(pop_err[2])
  );

  llc_in_fifo #(.W(DMA_W), .DEPTH(DEPTH)) u_dma_req_in (
    .clk(clk), .rst(rst),
    .in_valid_i(llc_dma_req_in_valid), .in_ready_o(llc_dma_req_in_ready), .in_data_i(llc_dma_req_in_data),
    .out_valid_o(llc_dma_req_in_valid_int), .out_data_o(llc_dma_req_in_data_int),
    .pop_i(pop_dma_req_in), .pop_err_o(pop_err[3])
  );

  // Set has priority over clear so a re-stall in the consume cycle is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stalled_valid_q <= 1'b0;
      stalled_data_q  <= '0;
      err_q           <= 1'b0;
    end else begin
      if (set_req_in_stalled) begin
        stalled_valid_q <= 1'b1;
        stalled_data_q  <= req_in_stalled_data_in;
      end else if (clr_req_in_stalled_valid) begin
        stalled_valid_q <= 1'b0;
      end
      if (|pop_err) err_q <= 1'b1;
    end
  end

  assign req_in_stalled_valid = stalled_valid_q;
  assign req_in_stalled_data  = stalled_data_q;
  assign err_pop_empty        = err_q;

endmodule
